divider: RTL and testbench
==========================

# divider

Sequential unsigned 32-bit divider: the inverse companion of the combinational multiplier in the ALU datapath. It accepts a dividend/divisor pair on a start pulse qualified by the ALU control code, and iterates one restoring shift-subtract step per clock for 32 cycles. It returns remainder and quotient packed as a 64-bit HI/LO word on the same `dataOut` bus shape the multiplier uses. A busy/done handshake lets the control unit stall while the result forms.

## Interface
- `WIDTH`, default 32: operand width; `dataOut` is 2*WIDTH.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `signal`: input, 3 bits. ALU control code; the block acts only when it equals `DIVU` (3'b101).
- `start`: input, 1 bit. Request pulse, sampled on the rising edge.
- `dataA`: input, WIDTH bits. Dividend, latched at accept.
- `dataB`: input, WIDTH bits. Divisor, latched at accept.
- `dataOut`: output, 2*WIDTH bits. {remainder[63:32], quotient[31:0]}, registered.
- `busy`: output, 1 bit. High while the block is in CALC or DONE.
- `done`: output, 1 bit. One-cycle pulse; `dataOut` is valid and new during this cycle.
- `div_by_zero`: output, 1 bit. Sticky status of the last completed operation.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterating; 5-bit counter `cnt` runs 0..31.
  - DONE: result presented for one cycle.
- Accept: start only in IDLE with `start`=1 and `signal`=DIVU.
  - Latch divisor D = `dataB`.
  - Load 64-bit shift register {R,Q} = {32'b0, `dataA`}.
  - Set `cnt`=0 and go to CALC.
  - Clear `div_by_zero`.
- In CALC, `start` is ignored. In DONE, `start` is also ignored.
- `start` with any other `signal` value is ignored in every state.
- One CALC iteration does the following:
  - Shift {R,Q} left by 1 into S.
  - Form trial T = {1'b0, S[63:32]} - {1'b0, D} (33 bits).
  - If T[32]==0: R = T[31:0], Q = {S[31:1], 1'b1}.
  - Otherwise: {R,Q} = {S[63:32], S[31:1], 1'b0}.
- After the iteration with `cnt`==31:
  - Load `dataOut` with {R,Q}.
  - Go to DONE.
- DONE goes to IDLE unconditionally on the next edge.
- Divide by zero (`dataB`==0 at accept):
  - Skip CALC and go straight to DONE.
  - `dataOut` = {`dataA`, 32'hFFFF_FFFF}.
  - `div_by_zero`=1.
- `dataOut` holds its last value until the next completion and is never cleared except by reset.
- Arithmetic is unsigned only. The result satisfies `dataA` = Q*D + R with R < D.

## Timing
- Reset (asynchronous assert, any state): state IDLE, `dataOut`=0, `busy`=0, `done`=0, `div_by_zero`=0, `cnt`=0. An in-flight operation is aborted with no `done`.
- Reset release: the first accept is possible on the first rising edge with `rst`=1.
- Normal latency: accept at edge E0, iterations at E1..E32, and `dataOut` updated at E32.
  - `done`=1 from E32 to E33.
  - IDLE at E33; next accept at E34 at the earliest.
- Divide-by-zero latency: accept and result both at E0; `done`=1 from E0 to E1; IDLE at E1.
- `busy` rises at the accept edge and falls at the edge that leaves DONE.
- `done` and `busy` are both high during the DONE cycle.
- `dataA`/`dataB` may change freely after the accept edge.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `MUL`=3'b100 and `DIVU`=3'b101.
  - `WIDTH`=32.
  - State enum {IDLE, CALC, DONE}.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: {R,Q} and D.
  - Outputs: next {R,Q}.
  - Instantiated once inside the FSM.

## Test plan
- 100/7: `dataA`=100, `dataB`=7, start at E0. `done` is high E32–E33 only; `dataOut`=64'h00000002_0000000E; `div_by_zero`=0.
- FFFFFFFF/1 and 3/10:
  - FFFFFFFF/1 gives `dataOut`=64'h00000000_FFFFFFFF.
  - 3/10 gives `dataOut`=64'h00000003_00000000.
- Divide by zero, 5/0: `done` is high E0–E1; `dataOut`=64'h00000005_FFFFFFFF; `div_by_zero`=1. It clears on the next accepted 9/3, which yields 64'h00000000_00000003.
- Busy/ignore:
  - A second start (with `signal`=DIVU) at E10 is ignored, and the result still matches the first operands.
  - Start with `signal`=MUL in IDLE leaves `busy`=0 and `dataOut` unchanged.
- Reset mid-operation: drop `rst` at E15. All outputs read 0 immediately and no `done` appears. After release, 50/8 completes with `dataOut`=64'h00000002_00000006.
- Randomized 1000 pairs against the reference model Q=A/B, R=A%B, including B=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control opcodes, datapath width and divider FSM states.
package alu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] MUL  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on the packed {R,Q} register against divisor D.
module div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [2*Width-1:0] rq_i,
  input  logic [Width-1:0]   d_i,
  output logic [2*Width-1:0] rq_o
);

  logic [2*Width-1:0] shifted;
  logic [Width:0]     trial;

  always_comb begin
    shifted = rq_i << 1;
    // The extra top bit is a borrow flag: set means the partial remainder was smaller than D.
    trial   = {1'b0, shifted[2*Width-1:Width]} - {1'b0, d_i};
    if (!trial[Width]) begin
      rq_o = {trial[Width-1:0], shifted[Width-1:1], 1'b1};
    end else begin
      rq_o = {shifted[2*Width-1:Width], shifted[Width-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider: one restoring step per clock, result as {remainder, quotient}.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         signal,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);
  import alu_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  div_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] rq_q;
  logic [2*WIDTH-1:0] rq_next;
  logic [WIDTH-1:0]   d_q;
  logic [2*WIDTH-1:0] data_out_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  div_step #(
    .Width (WIDTH)
  ) u_div_step (
    .rq_i (rq_q),
    .d_i  (d_q),
    .rq_o (rq_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rq_q       <= '0;
      d_q        <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (signal == DIVU)) begin
            d_q    <= dataB;
            rq_q   <= {{WIDTH{1'b0}}, dataA};
            cnt_q  <= '0;
            busy_q <= 1'b1;
            dbz_q  <= (dataB == '0);
            // A zero divisor bypasses iteration and reports a saturated quotient.
            if (dataB == '0) begin
              data_out_q <= {dataA, {WIDTH{1'b1}}};
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rq_q  <= rq_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            data_out_q <= rq_next;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataOut     = data_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor pops them on done.
module tb_divider;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  signal;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic [63:0] data;
    logic        dbz;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] last_out = '0;

  divider #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signal      (signal),
    .start       (start),
    .dataA       (dataA),
    .dataB       (dataB),
    .dataOut     (dataOut),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", dataOut, e.data);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        chk("busy_in_done", {63'd0, busy}, 64'd1);
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t e;
    int   lat;
    bit   seen;
    e.dbz  = (b == 0);
    e.data = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    @(posedge clk); #1;
    signal = DIVU; start = 1'b1; dataA = a; dataB = b;
    sb_q.push_back(e);
    @(posedge clk); #1;  // accept edge E0
    start = 1'b0; dataA = $urandom; dataB = $urandom;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("dbz_after_accept", {63'd0, div_by_zero}, {63'd0, e.dbz});
    lat  = 0;
    seen = (done === 1'b1);
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 9) begin
        signal = DIVU; start = 1'b1; dataA = 32'd1; dataB = 32'd1;
      end
      if (poke && lat == 10) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", 64'd1, 64'd0);
    end else begin
      chk("latency", 64'(lat), (b == 0) ? 64'd0 : 64'd32);
      @(posedge clk); #1;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("busy_cleared", {63'd0, busy}, 64'd0);
      chk("data_hold", dataOut, e.data);
    end
    last_out = e.data;
  endtask

  initial begin
    int dcount;
    logic [31:0] ra, rb;
    rst = 1'b0; signal = 3'b000; start = 1'b0; dataA = '0; dataB = '0;
    #2;
    chk("reset_dataOut", dataOut, 64'd0);
    chk("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run(32'd100, 32'd7, 1'b0);
    chk("vec_100_7", last_out, 64'h00000002_0000000E);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    run(32'd3, 32'd10, 1'b0);
    run(32'd5, 32'd0, 1'b0);
    run(32'd9, 32'd3, 1'b0);
    run(32'd1000, 32'd33, 1'b1);

    // Non-DIVU request in IDLE is ignored.
    @(posedge clk); #1;
    signal = MUL; start = 1'b1; dataA = 32'd77; dataB = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mul_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("mul_busy_later", {63'd0, busy}, 64'd0);
    chk("mul_dataOut", dataOut, last_out);

    // Abort an operation with reset partway through.
    @(posedge clk); #1;
    signal = DIVU; start = 1'b1; dataA = 32'd123456; dataB = 32'd789;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_dataOut", dataOut, 64'd0);
    chk("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(posedge clk); #2 rst = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run(32'd50, 32'd8, 1'b0);
    chk("vec_50_8", last_out, 64'h00000002_00000006);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 16);
        3:       rb = ra;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run(ra, rb, 1'b0);
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
